// File: rtl/cpu_types_pkg.sv
// ============================================================================
// Module     : cpu_types_pkg
// Description: Shared CPU datapath types and constants.
// Revision   : 1.0
// ============================================================================
`default_nettype none

package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [4:0]        regbits_t;

    localparam regbits_t REG_ZERO = 5'd0;

endpackage

`default_nettype wire

// File: rtl/register_file_mp_if.sv
// ============================================================================
// Module     : register_file_mp_if
// Description: Read/write/claim bundle between pipeline stages and the GPR file.
// Revision   : 1.0
// ============================================================================
`default_nettype none

interface register_file_mp_if
    import cpu_types_pkg::*;
#(
    parameter int NREAD  = 2,
    parameter int NWRITE = 1,
    parameter int NREGS  = 32
) ();

    localparam int AW = $clog2(NREGS);

    logic [NREAD*AW-1:0]      rsel;
    logic [NREAD*WORD_W-1:0]  rdat;
    logic [NREAD-1:0]         rbusy;
    logic [NWRITE-1:0]        wen;
    logic [NWRITE*AW-1:0]     wsel;
    logic [NWRITE*WORD_W-1:0] wdat;
    logic                     claim_en;
    logic [AW-1:0]            claim_sel;
    logic [NREGS-1:0]         busy_vec;

    modport rf (
        input  rsel, wen, wsel, wdat, claim_en, claim_sel,
        output rdat, rbusy, busy_vec
    );

    modport tb (
        output rsel, wen, wsel, wdat, claim_en, claim_sel,
        input  rdat, rbusy, busy_vec
    );

endinterface

`default_nettype wire

// File: rtl/rf_scoreboard.sv
// ============================================================================
// Module     : rf_scoreboard
// Description: One busy bit per register; decode claims, writeback releases.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module rf_scoreboard
    import cpu_types_pkg::*;
#(
    parameter int NREGS  = 32,
    parameter int NWRITE = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  wire logic                 clk,
    input  wire logic                 n_rst,
    input  wire logic                 claim_en_i,
    input  wire logic [AW-1:0]        claim_sel_i,
    input  wire logic [NWRITE-1:0]    wen_i,
    input  wire logic [NWRITE*AW-1:0] wsel_i,
    output logic      [NREGS-1:0]     busy_vec_o
);

    localparam logic [AW-1:0] SEL_ZERO = AW'(REG_ZERO);

    logic [NREGS-1:0] set_vec;
    logic [NREGS-1:0] clr_vec;
    logic [NREGS-1:0] busy_d;
    logic [NREGS-1:0] busy_q;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (claim_en_i) begin
            set_vec[claim_sel_i] = 1'b1;
        end
        for (int w = 0; w < NWRITE; w++) begin
            if (wen_i[w]) begin
                clr_vec[wsel_i[w*AW +: AW]] = 1'b1;
            end
        end
        // A fresh claim outranks the retiring writeback of the older producer.
        busy_d           = (busy_q & ~clr_vec) | set_vec;
        busy_d[SEL_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec_o = busy_q;

endmodule

`default_nettype wire

// File: rtl/register_file_mp.sv
// ============================================================================
// Module     : register_file_mp
// Description: Multi-ported MIPS GPR file with write bypass and busy scoreboard.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module register_file_mp
    import cpu_types_pkg::*;
#(
    parameter int NREAD  = 2,
    parameter int NWRITE = 1,
    parameter int BYPASS = 1,
    parameter int NREGS  = 32
) (
    input  wire logic       clk,
    input  wire logic       n_rst,
    register_file_mp_if.rf  bus
);

    localparam int AW = $clog2(NREGS);
    localparam logic [AW-1:0] SEL_ZERO = AW'(REG_ZERO);

    word_t                    regs_q [NREGS];
    word_t                    regs_d [NREGS];
    logic [NREGS-1:0]         busy_vec;
    logic [AW-1:0]            wr_sel;
    logic [AW-1:0]            rd_sel;
    logic                     rd_hit;
    logic                     rd_claimed;
    logic [NREAD*WORD_W-1:0]  rdat_c;
    logic [NREAD-1:0]         rbusy_c;

    // Ascending port order lets the highest-index writer land last.
    always_comb begin
        regs_d = regs_q;
        wr_sel = '0;
        for (int w = 0; w < NWRITE; w++) begin
            wr_sel = bus.wsel[w*AW +: AW];
            if (bus.wen[w] && (wr_sel != SEL_ZERO)) begin
                regs_d[wr_sel] = bus.wdat[w*WORD_W +: WORD_W];
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    rf_scoreboard #(
        .NREGS  (NREGS),
        .NWRITE (NWRITE)
    ) u_scoreboard (
        .clk         (clk),
        .n_rst       (n_rst),
        .claim_en_i  (bus.claim_en),
        .claim_sel_i (bus.claim_sel),
        .wen_i       (bus.wen),
        .wsel_i      (bus.wsel),
        .busy_vec_o  (busy_vec)
    );

    always_comb begin
        rdat_c     = '0;
        rbusy_c    = '0;
        rd_sel     = '0;
        rd_hit     = 1'b0;
        rd_claimed = 1'b0;
        for (int p = 0; p < NREAD; p++) begin
            rd_sel                        = bus.rsel[p*AW +: AW];
            rd_hit                        = 1'b0;
            rdat_c[p*WORD_W +: WORD_W]    = regs_q[rd_sel];
            rbusy_c[p]                    = busy_vec[rd_sel];
            if (BYPASS != 0) begin
                for (int w = 0; w < NWRITE; w++) begin
                    if (bus.wen[w] && (bus.wsel[w*AW +: AW] == rd_sel)) begin
                        rd_hit                     = 1'b1;
                        rdat_c[p*WORD_W +: WORD_W] = bus.wdat[w*WORD_W +: WORD_W];
                    end
                end
            end
            // A retiring write frees the register unless decode re-claims it now.
            rd_claimed = bus.claim_en && (bus.claim_sel == rd_sel);
            if (rd_hit && !rd_claimed) begin
                rbusy_c[p] = 1'b0;
            end
            if (rd_sel == SEL_ZERO) begin
                rdat_c[p*WORD_W +: WORD_W] = '0;
                rbusy_c[p]                 = 1'b0;
            end
        end
    end

    assign bus.rdat     = rdat_c;
    assign bus.rbusy    = rbusy_c;
    assign bus.busy_vec = busy_vec;

endmodule

`default_nettype wire
